// File: rtl/lutram_fifo_pkg.sv
// Shared defaults for lutram_fifo: word/pointer widths and the depth helper.
package lutram_fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_BITS_DEF  = 5;

    function automatic int unsigned depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/lutram_fifo_lutram.sv
// Distributed-RAM storage block: synchronous write, asynchronous read.
module lutram #(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [RAM_ADDR_BITS-1:0] waddr,
    input  logic [RAM_WIDTH-1:0]     wdata,
    input  logic [RAM_ADDR_BITS-1:0] raddr,
    output logic [RAM_WIDTH-1:0]     rdata
);

    logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO over the lutram storage block.
// Define LUTRAM_FIFO_OUT_REG_EN to add a registered output stage (capacity DEPTH+1).
module lutram_fifo
    import lutram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
`ifdef LUTRAM_FIFO_OUT_REG_EN
    output logic [ADDR_BITS+1:0]  count_o
`else
    output logic [ADDR_BITS:0]    count_o
`endif
);

    localparam int unsigned DEPTH = depth(ADDR_BITS);
    localparam logic [ADDR_BITS:0] FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS:0]    wr_ptr, rd_ptr, ram_count;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push, pop, rd_adv;

    assign wready_o = (ram_count != FULL);
    assign push     = wvalid_i & wready_o;

    lutram #(
        .RAM_WIDTH     (DATA_WIDTH),
        .RAM_ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk_i),
        .we    (push),
        .waddr (wr_ptr[ADDR_BITS-1:0]),
        .wdata (wdata_i),
        .raddr (rd_ptr[ADDR_BITS-1:0]),
        .rdata (ram_rdata)
    );

`ifdef LUTRAM_FIFO_OUT_REG_EN
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // RAM head moves into the output flop whenever that flop is free or being consumed.
    assign pop      = out_valid & rready_i;
    assign rd_adv   = (ram_count != '0) & (~out_valid | pop);
    assign rvalid_o = out_valid;
    assign rdata_o  = out_data;
    assign count_o  = {1'b0, ram_count} + {{(ADDR_BITS+1){1'b0}}, out_valid};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (rd_adv) begin
            out_valid <= 1'b1;
            out_data  <= ram_rdata;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign pop      = rvalid_o & rready_i;
    assign rd_adv   = pop;
    assign rvalid_o = (ram_count != '0);
    assign rdata_o  = ram_rdata;
    assign count_o  = ram_count;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, rd_adv})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
        end
    end

    // DEPTH is kept for readability of the full encoding above.
    if (DEPTH != (1 << ADDR_BITS)) begin : g_depth_check
        $error("lutram_fifo: depth helper mismatch");
    end

endmodule

// File: tb/tb_lutram_fifo.sv
// Self-checking bench for lutram_fifo: queue model checked every cycle plus literal pins.
// Honours LUTRAM_FIFO_OUT_REG_EN when the design is built with it.
module tb_lutram_fifo;

    localparam int DW    = 8;
    localparam int AB    = 5;
    localparam int DEPTH = 32;
`ifdef LUTRAM_FIFO_OUT_REG_EN
    localparam int CW  = AB + 2;
    localparam int CAP = DEPTH + 1;
`else
    localparam int CW  = AB + 1;
    localparam int CAP = DEPTH;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    lutram_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wdata_i  (wdata),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .count_o  (count)
    );

    always #5 clk = ~clk;

    // Model: ram queue (plus an output slot when the output stage exists).
    logic [DW-1:0] q[$];
    bit            ov = 0;
    logic [DW-1:0] od = '0;

    function automatic int m_count();
`ifdef LUTRAM_FIFO_OUT_REG_EN
        return q.size() + int'(ov);
`else
        return q.size();
`endif
    endfunction

    function automatic bit m_rvalid();
`ifdef LUTRAM_FIFO_OUT_REG_EN
        return ov;
`else
        return q.size() != 0;
`endif
    endfunction

    function automatic logic [DW-1:0] m_rdata();
`ifdef LUTRAM_FIFO_OUT_REG_EN
        return od;
`else
        return q[0];
`endif
    endfunction

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (rst) begin
            q.delete();
            ov = 0;
            od = '0;
        end else begin
            do_push = wvalid && (q.size() != DEPTH);
            do_pop  = m_rvalid() && rready;
`ifdef LUTRAM_FIFO_OUT_REG_EN
            if (q.size() != 0 && (!ov || do_pop)) begin
                od = q.pop_front();
                ov = 1;
            end else if (do_pop) begin
                ov = 0;
            end
`else
            if (do_pop) void'(q.pop_front());
`endif
            if (do_push) q.push_back(wdata);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    bit started = 0;
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("model_count", int'(count), m_count());
            chk("model_rvalid", int'(rvalid), int'(m_rvalid()));
            chk("model_wready", int'(wready), int'(q.size() != DEPTH));
            if (m_rvalid()) chk("model_rdata", int'(rdata), int'(m_rdata()));
        end
    end

    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, '0, 0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        started = 1;
        chk("reset_count", int'(count), 0);
        chk("reset_rvalid", int'(rvalid), 0);
        chk("reset_wready", int'(wready), 1);

        // 1: single word; with the output stage rvalid follows one cycle later
        step(1, 8'hA5, 0);
`ifdef LUTRAM_FIFO_OUT_REG_EN
        chk("t1_rvalid_lat1", int'(rvalid), 0);
        step(0, '0, 0);
`endif
        chk("t1_rvalid", int'(rvalid), 1);
        chk("t1_rdata", int'(rdata), 8'hA5);
        chk("t1_count", int'(count), 1);
        step(0, '0, 1);
        chk("t1_pop_rvalid", int'(rvalid), 0);
        chk("t1_pop_count", int'(count), 0);

        // 2: fill to capacity, extra write ignored, ordered drain
        for (int i = 0; i < CAP; i++) step(1, DW'(i), 0);
        step(0, '0, 0);
        chk("t2_full_wready", int'(wready), 0);
        chk("t2_full_count", int'(count), CAP);
        step(1, 8'hEE, 0);
        chk("t2_ignored_count", int'(count), CAP);
        for (int i = 0; i < CAP; i++) begin
            chk("t2_drain_data", int'(rdata), i);
            step(0, '0, 1);
        end
        chk("t2_empty", int'(rvalid), 0);

        // 3: full with push and pop together: only the pop happens
        for (int i = 0; i < CAP; i++) step(1, DW'(8'h40 + i), 0);
        step(0, '0, 0);
        step(1, 8'h77, 1);
        chk("t3_pop_only_count", int'(count), CAP - 1);
        chk("t3_wready_back", int'(wready), 1);
        step(1, 8'h77, 0);
        chk("t3_push_count", int'(count), CAP);
        for (int i = 0; i < CAP; i++) begin
            chk("t3_drain_data", int'(rdata), (i == CAP - 1) ? 8'h77 : 8'h41 + i);
            step(0, '0, 1);
        end

        // 4: streaming at occupancy 5 across pointer wraps
        do_reset();
        for (int i = 0; i < 5; i++) step(1, DW'(i * 7), 0);
        step(0, '0, 0);
        for (int i = 0; i < 100; i++) begin
            chk("t4_head", int'(rdata), (i * 7) % 256);
            step(1, DW'((i + 5) * 7), 1);
            chk("t4_count", int'(count), 5);
        end
        for (int i = 0; i < 5; i++) step(0, '0, 1);
        step(0, '0, 0);
        chk("t4_drained", int'(count), 0);

        // 5: pop requests on empty FIFO do nothing
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        chk("t5_count", int'(count), 0);
        step(1, 8'h5A, 0);
        step(0, '0, 0);
        chk("t5_rdata", int'(rdata), 8'h5A);
        step(0, '0, 1);

        // 6: reset mid-stream overrides push/pop
        for (int i = 0; i < 12; i++) step(1, DW'(8'h90 + i), 0);
        step(0, '0, 0);
        chk("t6_pre_count", int'(count), 12);
        rst = 1'b1;
        step(1, 8'hFF, 1);
        rst = 1'b0;
        chk("t6_count", int'(count), 0);
        chk("t6_rvalid", int'(rvalid), 0);
        chk("t6_wready", int'(wready), 1);
        step(1, 8'h3C, 0);
        step(0, '0, 0);
        chk("t6_rdata", int'(rdata), 8'h3C);
        step(0, '0, 1);
        step(0, '0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
